// File: rtl/simon32_64.sv
// Simon32/64 block cipher unrolled into NumStages round stages.
// Key words travel with each block, so the key may change every cycle.
module simon32_64 #(
  parameter int NumStages = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] plaintext,
  input  logic [63:0] key,
  output logic [31:0] ciphertext
);

  localparam int Rps = 32 / NumStages;

  localparam logic [0:31] Z0 =
    32'b11111010001001010110000111001101;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [63:0] k;
  } st_t;

  // One round plus one key-schedule step.
  // st.k packs {k3, k2, k1, k0}.
  function automatic st_t do_round(
    input st_t        st,
    input logic [4:0] i
  );
    logic [15:0] f;
    logic [15:0] t;
    logic [15:0] nk;
    st_t         o;
    f = ({st.x[14:0], st.x[15]} &
         {st.x[7:0], st.x[15:8]}) ^
        {st.x[13:0], st.x[15:14]};
    t = {st.k[50:48], st.k[63:51]} ^
        st.k[31:16];
    nk = 16'hFFFC ^ {15'd0, Z0[i]} ^
         st.k[15:0] ^ t ^ {t[0], t[15:1]};
    o.x = st.y ^ f ^ st.k[15:0];
    o.y = st.x;
    o.k = {nk, st.k[63:16]};
    return o;
  endfunction

  // data_q[0]/key_q[0] form the input register;
  // data_q[s+1] holds the block leaving stage s.
  logic [31:0] data_d [NumStages+1];
  logic [31:0] data_q [NumStages+1];
  logic [63:0] key_d  [NumStages];
  logic [63:0] key_q  [NumStages];
  logic [31:0] ct_d;
  logic [31:0] ct_q;

  always_comb begin
    data_d[0] = plaintext;
    key_d[0]  = key;
    ct_d      = data_q[NumStages];
  end

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    if (s < NumStages - 1) begin : g_mid
      always_comb begin
        st_t cur;
        cur = {data_q[s], key_q[s]};
        for (int r = 0; r < Rps; r++) begin
          cur = do_round(cur, 5'(s * Rps + r));
        end
        data_d[s+1] = {cur.x, cur.y};
        key_d[s+1]  = cur.k;
      end
    end else begin : g_last
      // Nothing downstream needs the last key words.
      always_comb begin
        st_t cur;
        cur = {data_q[s], key_q[s]};
        for (int r = 0; r < Rps; r++) begin
          cur = do_round(cur, 5'(s * Rps + r));
        end
        data_d[s+1] = {cur.x, cur.y};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '{default: '0};
      key_q  <= '{default: '0};
      ct_q   <= '0;
    end else begin
      data_q <= data_d;
      key_q  <= key_d;
      ct_q   <= ct_d;
    end
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_simon32_64.sv
// Scoreboard bench for simon32_64 at NumStages 32, 4 and 1.
// Inputs are shared; each instance checks at its own latency.
module tb_simon32_64;

  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_PT  = 32'h65656877;
  localparam logic [31:0] KAT_CT  = 32'hC69BE9BB;

  typedef struct {
    int          due;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pt;
  logic [63:0] key_in;
  logic [31:0] ct [3];

  int   cyc;
  int   n_run;
  int   n_fail;
  int   lat [3] = '{34, 6, 3};
  exp_t sb [3][$];

  simon32_64 #(.NumStages(32)) dut32 (
    .clk(clk), .reset(rst_n), .plaintext(pt),
    .key(key_in), .ciphertext(ct[0])
  );
  simon32_64 #(.NumStages(4)) dut4 (
    .clk(clk), .reset(rst_n), .plaintext(pt),
    .key(key_in), .ciphertext(ct[1])
  );
  simon32_64 #(.NumStages(1)) dut1 (
    .clk(clk), .reset(rst_n), .plaintext(pt),
    .key(key_in), .ciphertext(ct[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rol16(
    input logic [15:0] v, input int n
  );
    logic [31:0] d;
    d = {v, v} << n;
    return d[31:16];
  endfunction

  function automatic logic [15:0] ror16(
    input logic [15:0] v, input int n
  );
    logic [31:0] d;
    d = {v, v} >> n;
    return d[15:0];
  endfunction

  // Straight software Simon32/64: expand all keys, then 32 rounds.
  function automatic logic [31:0] simon_ref(
    input logic [31:0] p, input logic [63:0] k
  );
    logic [15:0] ks [32];
    logic [61:0] z;
    logic [15:0] x, y, t, tmp;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    ks[0] = k[15:0];
    ks[1] = k[31:16];
    ks[2] = k[47:32];
    ks[3] = k[63:48];
    for (int i = 0; i < 28; i++) begin
      t = ror16(ks[i+3], 3) ^ ks[i+1];
      ks[i+4] = 16'hFFFC ^ {15'd0, z[61-i]} ^ ks[i] ^ t ^ ror16(t, 1);
    end
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ ks[i];
      y = tmp;
    end
    return {x, y};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      while (sb[d].size() > 0 && sb[d][0].due <= cyc) begin
        exp_t e;
        e = sb[d].pop_front();
        n_run++;
        if (e.due != cyc || ct[d] !== e.exp) begin
          n_fail++;
          $display("FAIL sb_dut%0d: got %h at edge %0d, want %h at edge %0d",
                   d, ct[d], cyc, e.exp, e.due);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] e);
    for (int d = 0; d < 3; d++) begin
      sb[d].push_back('{due: cyc + lat[d], exp: e});
    end
  endtask

  task automatic send(
    input logic [31:0] p, input logic [63:0] k, input bit chk
  );
    @(negedge clk);
    pt = p;
    key_in = k;
    if (chk) push_exp(simon_ref(p, k));
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (i < 100 &&
           (sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
      @(negedge clk);
      i++;
    end
    if ((sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_%s: %0d entries left, want 0", name,
               sb[0].size() + sb[1].size() + sb[2].size());
      for (int d = 0; d < 3; d++) sb[d].delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pt = $urandom;
    key_in = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_run++;
      if (ct[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_dut%0d: got %h, want 00000000", d, ct[d]);
      end
    end
  endtask

  task automatic test_kat_stream;
    logic [31:0] bp;
    logic [63:0] bk;
    bp = 32'h12345678;
    bk = 64'h0f1e2d3c4b5a6978;
    @(negedge clk);
    rst_n = 1'b1;
    pt = KAT_PT;
    key_in = KAT_KEY;
    push_exp(KAT_CT);
    send(bp, bk, 1'b1);
    @(negedge clk);
    pt = KAT_PT;
    key_in = KAT_KEY;
    push_exp(KAT_CT);
    send(~bp, ~bk, 1'b1);
    drain("kat");
  endtask

  task automatic test_key_alt;
    logic [63:0] ka, kb;
    logic [31:0] p;
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    p = $urandom;
    for (int i = 0; i < 16; i++) send(p, i[0] ? kb : ka, 1'b1);
    drain("key_alt");
  endtask

  task automatic test_hold;
    logic [63:0] k;
    logic [31:0] p;
    k = {$urandom, $urandom};
    p = $urandom;
    for (int i = 0; i < 40; i++) send(p, k, 1'b1);
    drain("hold");
  endtask

  task automatic test_midstream_reset;
    logic [31:0] xp, yp, xe;
    logic [63:0] xk, yk;
    xp = $urandom;
    xk = {$urandom, $urandom};
    yp = ~xp;
    yk = {$urandom, $urandom};
    xe = simon_ref(xp, xk);
    send(xp, xk, 1'b0);
    send($urandom, {$urandom, $urandom}, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_run++;
      if (ct[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_reset_dut%0d: got %h, want 00000000", d, ct[d]);
      end
    end
    rst_n = 1'b1;
    pt = yp;
    key_in = yk;
    push_exp(simon_ref(yp, yk));
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (j < lat[d]) begin
          n_run++;
          if (ct[d] === xe) begin
            n_fail++;
            $display("FAIL discard_dut%0d: got %h at edge +%0d, want not %h",
                     d, ct[d], j, xe);
          end
        end
      end
    end
    drain("mid_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, {$urandom, $urandom}, 1'b1);
    end
    drain("random");
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_kat_stream();
    test_key_alt();
    test_hold();
    test_midstream_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simon32_64.md
SIMON32_64 -- requirements
Module: simon32_64

Interface
REQ-001 Parameter NumStages, default 32: number of round pipeline stages; legal values 1, 2, 4, 8, 16, 32; each stage performs 32/NumStages rounds.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset asserted).
REQ-004 plaintext  input  32  block to encrypt; bits [31:16] = x (left word), [15:0] = y (right word).
REQ-005 key  input  64  master key; k0 = key[15:0], k1 = key[31:16], k2 = key[47:32], k3 = key[63:48].
REQ-006 ciphertext  output  32  encrypted block, same x/y packing as plaintext; registered output.

Function
REQ-007 The block SHALL implement Simon32/64: word n = 16, m = 4 key words, T = 32 rounds, constant sequence z0.
REQ-008 Round function: f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x); round i maps (x, y) -> (y ^ f(x) ^ k_i, x), for i = 0..31.
REQ-009 Key schedule, for i = 0..27: t = ROR3(k_{i+3}) ^ k_{i+1}; k_{i+4} = 16'hFFFC ^ z0[i] ^ k_i ^ t ^ ROR1(t).
REQ-010 z0 in index order 0..61 SHALL be 11111010001001010110000111001101111101000100101011000011100110.
REQ-011 ciphertext = {x_32, y_32} after round 31; all rotates are 16-bit circular.
REQ-012 plaintext and key SHALL be captured in an input register every clock; no enable and no handshake.
REQ-013 The block SHALL be fully pipelined: NumStages round stages, then the output register.
REQ-014 Latency SHALL be NumStages+2 rising edges from input sampling to ciphertext update; throughput one block per clock.
REQ-015 Key expansion SHALL be pipelined alongside the data: each stage carries the four current key words with its block, so the key may differ on every cycle.
REQ-016 Blocks SHALL emerge in input order with no reordering, drops or stalls.
REQ-017 Holding plaintext/key constant SHALL yield a constant ciphertext after the latency elapses.

Reset
REQ-018 While reset = 0 at a rising edge, the input register, all stage registers (data and key words) and ciphertext SHALL clear to 0.
REQ-019 After reset release, ciphertext is don't-care for the first NumStages+1 edges; the first input sampled after release SHALL appear at edge NumStages+2.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight blocks; no partially processed block may appear after release.
REQ-021 There SHALL be no valid/ready signalling; downstream logic counts cycles from reset release.

Verification
REQ-022 Known answer: key 64'h1918111009080100, plaintext 32'h65656877 -> ciphertext 32'hC69BE9BB exactly NumStages+2 edges later.
REQ-023 Streaming: apply the known-answer vector, a different vector B, then the known-answer vector on consecutive cycles -> outputs C69BE9BB, E(B), C69BE9BB on consecutive cycles.
REQ-024 Per-cycle key change: alternate two keys with a fixed plaintext every cycle -> each output matches a software model of its own key, proving key/data pipeline alignment.
REQ-025 Reset: hold reset = 0 for 2 cycles -> ciphertext = 0; inject a block mid-stream, then reset -> that block never appears after release.
REQ-026 Parameter sweep: repeat REQ-022 and REQ-023 for NumStages = 1, 4 and 32 -> same values at latency NumStages+2.
REQ-027 Random regression: 1000 random plaintext/key pairs streamed back-to-back -> every output matches the reference model, offset by the latency.
